// File: rtl/pipeline_flow_ctrl.sv
// Pipeline flow controller: per-register load enables and NOP inserts from
// external stalls, a pended branch flush and a load-use hazard sequencer.
module pipeline_flow_ctrl #(
    parameter int NUM_STAGES          = 4,
    parameter int HAZARD_STALL_CYCLES = 1,
    parameter int FLUSH_DEPTH         = 2,
    parameter int CNT_W               = 8,
    parameter int TIMEOUT             = 200
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] stall_req,
    input  logic                  hazard_req,
    input  logic                  flush_req,
    input  logic                  timeout_clr,
    output logic [NUM_STAGES-1:0] flow,
    output logic [NUM_STAGES-1:0] bubble,
    output logic                  stall_active,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic                  timeout
);

    localparam int HC_W = $clog2(HAZARD_STALL_CYCLES + 1);
    localparam logic [NUM_STAGES-1:0] FLUSH_MASK = {NUM_STAGES{1'b1}} >> (NUM_STAGES - FLUSH_DEPTH);
    localparam logic [NUM_STAGES-1:0] HAZ_BUBBLE = NUM_STAGES'(2);
    localparam logic [CNT_W-1:0]      CNT_MAX    = '1;

    typedef enum logic {IDLE, HOLD} haz_state_e;

    haz_state_e      state_q, state_d;
    logic [HC_W-1:0] haz_cnt_q, haz_cnt_d;
    logic            flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    logic                  any_stall;
    logic                  flush_cycle;
    logic                  hazard_cycle;
    logic [NUM_STAGES-1:0] held;

    // held[j] is set when some register at or above j requests a stall.
    function automatic logic [NUM_STAGES-1:0] stall_mask(input logic [NUM_STAGES-1:0] req);
        logic [NUM_STAGES-1:0] m;
        logic                  acc;
        m   = '0;
        acc = 1'b0;
        for (int j = NUM_STAGES - 1; j >= 0; j--) begin
            acc  = acc | req[j];
            m[j] = acc;
        end
        return m;
    endfunction

    assign any_stall    = |stall_req;
    assign held         = stall_mask(stall_req);
    assign flush_cycle  = !any_stall && (flush_req || flush_pend_q);
    assign hazard_cycle = !any_stall && !flush_cycle && ((state_q == HOLD) || hazard_req);

    always_comb begin
        flow   = '1;
        bubble = '0;
        if (!rst_n) begin
            flow   = '0;
            bubble = '1;
        end else if (any_stall) begin
            flow = ~held;
            // The register just above the highest stalled one takes a NOP.
            for (int j = 1; j < NUM_STAGES; j++) begin
                bubble[j] = held[j-1] & ~held[j];
            end
        end else if (flush_cycle) begin
            bubble = FLUSH_MASK;
        end else if (hazard_cycle) begin
            flow[0] = 1'b0;
            bubble  = HAZ_BUBBLE;
        end
    end

    assign stall_active = ~&flow;

    always_comb begin
        state_d   = state_q;
        haz_cnt_d = haz_cnt_q;
        if (flush_cycle) begin
            state_d   = IDLE;
            haz_cnt_d = '0;
        end else if (hazard_cycle) begin
            if (state_q == IDLE) begin
                if (HAZARD_STALL_CYCLES > 1) begin
                    state_d   = HOLD;
                    haz_cnt_d = HC_W'(HAZARD_STALL_CYCLES - 1);
                end
            end else begin
                haz_cnt_d = haz_cnt_q - 1'b1;
                if (haz_cnt_q == HC_W'(1)) begin
                    state_d = IDLE;
                end
            end
        end
    end

    always_comb begin
        flush_pend_d = flush_cycle ? 1'b0 : (flush_pend_q | (flush_req & any_stall));
        if (!any_stall) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // Set only on the edge the count reaches TIMEOUT; set beats clear.
        timeout_d = (any_stall && (cnt_q == CNT_W'(TIMEOUT - 1))) | (timeout_q & ~timeout_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            haz_cnt_q    <= '0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            haz_cnt_q    <= haz_cnt_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign stall_cycles = cnt_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Bench for pipeline_flow_ctrl: directed vector table, corner sequences and a
// randomized run against a remaining-cycles reference model.
module tb_pipeline_flow_ctrl;

    localparam int TO  = 10;
    localparam int FD  = 2;
    localparam int CMX = 255;

    logic       clk;
    logic       rst_n;
    logic [3:0] stall_req;
    logic       hz, fl, clr;

    logic [3:0] f3, b3, f4, b4;
    logic       sa3, sa4, to3, to4;
    logic [7:0] sc3, sc4;

    int n_vec = 0;
    int n_err = 0;

    pipeline_flow_ctrl #(.NUM_STAGES(4), .HAZARD_STALL_CYCLES(3), .FLUSH_DEPTH(FD),
                         .CNT_W(8), .TIMEOUT(TO)) dut3 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .hazard_req(hz),
        .flush_req(fl), .timeout_clr(clr), .flow(f3), .bubble(b3),
        .stall_active(sa3), .stall_cycles(sc3), .timeout(to3));

    pipeline_flow_ctrl #(.NUM_STAGES(4), .HAZARD_STALL_CYCLES(4), .FLUSH_DEPTH(FD),
                         .CNT_W(8), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst_n(rst_n), .stall_req(stall_req), .hazard_req(hz),
        .flush_req(fl), .timeout_clr(clr), .flow(f4), .bubble(b4),
        .stall_active(sa4), .stall_cycles(sc4), .timeout(to4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: hazard cycles still owed, pending flush, stall run length, watchdog.
    typedef struct {
        int rem;
        bit pend;
        int cnt;
        bit to;
    } mst_t;

    mst_t m3, m4;

    typedef struct {
        logic [3:0] st;
        logic       hz;
        logic       fl;
        logic       clr;
        logic [3:0] ef;
        logic [3:0] eb;
        int         ecnt;
    } vec_t;

    vec_t tbl[28];

    function automatic void mexp(input mst_t s, input logic [3:0] st, input logic h, input logic f_,
                                 output logic [3:0] ef, output logic [3:0] eb);
        int k;
        ef = 4'hF;
        eb = 4'h0;
        if (st != 4'h0) begin
            k = -1;
            for (int j = 0; j < 4; j++) if (st[j]) k = j;
            for (int j = 0; j < 4; j++) ef[j] = (j > k);
            if (k + 1 < 4) eb[k+1] = 1'b1;
        end else if (f_ || s.pend) begin
            eb = 4'((1 << FD) - 1);
        end else if (s.rem > 0 || h) begin
            ef = 4'b1110;
            eb = 4'b0010;
        end
    endfunction

    function automatic mst_t mnext(input mst_t s, input logic [3:0] st, input logic h,
                                   input logic f_, input logic c, input int hsc);
        mst_t n;
        bit any, fc, hc, tset;
        n    = s;
        any  = (st != 4'h0);
        fc   = !any && (f_ || s.pend);
        hc   = !any && !fc && (s.rem > 0 || h);
        if (fc) n.rem = 0;
        else if (hc) n.rem = (s.rem > 0) ? s.rem - 1 : hsc - 1;
        n.pend = fc ? 1'b0 : (s.pend | (f_ & any));
        tset   = any && (s.cnt + 1 == TO);
        n.cnt  = any ? ((s.cnt < CMX) ? s.cnt + 1 : CMX) : 0;
        n.to   = tset ? 1'b1 : (c ? 1'b0 : s.to);
        return n;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_model();
        logic [3:0] ef, eb;
        mexp(m3, stall_req, hz, fl, ef, eb);
        chk("flow3", 32'(f3), 32'(ef));
        chk("bubble3", 32'(b3), 32'(eb));
        chk("stall_active3", 32'(sa3), 32'(ef != 4'hF));
        chk("stall_cycles3", 32'(sc3), 32'(m3.cnt));
        chk("timeout3", 32'(to3), 32'(m3.to));
        mexp(m4, stall_req, hz, fl, ef, eb);
        chk("flow4", 32'(f4), 32'(ef));
        chk("bubble4", 32'(b4), 32'(eb));
        chk("stall_active4", 32'(sa4), 32'(ef != 4'hF));
        chk("stall_cycles4", 32'(sc4), 32'(m4.cnt));
        chk("timeout4", 32'(to4), 32'(m4.to));
    endtask

    task automatic cyc(input logic [3:0] st, input logic h, input logic f_, input logic c);
        @(posedge clk);
        #1;
        stall_req = st;
        hz        = h;
        fl        = f_;
        clr       = c;
        @(negedge clk);
        cmp_model();
        m3 = mnext(m3, st, h, f_, c, 3);
        m4 = mnext(m4, st, h, f_, c, 4);
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_flow"}, 32'({f4, f3}), 32'h00);
        chk({nm, "_bubble"}, 32'({b4, b3}), 32'hFF);
        chk({nm, "_stall_active"}, 32'({sa4, sa3}), 32'h3);
        chk({nm, "_stall_cycles"}, 32'({sc4, sc3}), 32'h0);
        chk({nm, "_timeout"}, 32'({to4, to3}), 32'h0);
    endtask

    function automatic mst_t mreset();
        mst_t z;
        z.rem  = 0;
        z.pend = 1'b0;
        z.cnt  = 0;
        z.to   = 1'b0;
        return z;
    endfunction

    initial begin
        // single-stage stall
        tbl[0]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 0};
        tbl[1]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 1};
        tbl[2]  = '{4'b0100, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 2};
        tbl[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 3};
        tbl[4]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 0};
        // hazard length
        tbl[5]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[6]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[8]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 0};
        // stall during hazard
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[11] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0010, 1};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[13] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 0};
        // pended flush
        tbl[14] = '{4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 0};
        tbl[15] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1};
        tbl[16] = '{4'b1000, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 2};
        tbl[17] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 3};
        tbl[18] = '{4'b1000, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0011, 5};
        tbl[20] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 0};
        // flush right after a hazard starts
        tbl[21] = '{4'b0000, 1'b1, 1'b0, 1'b0, 4'b1110, 4'b0010, 0};
        tbl[22] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0011, 0};
        tbl[23] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 0};
        // hazard dropped under stall; lower stall subsumed by higher
        tbl[24] = '{4'b0010, 1'b1, 1'b0, 1'b0, 4'b1100, 4'b0100, 0};
        tbl[25] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 1};
        tbl[26] = '{4'b0101, 1'b0, 1'b0, 1'b0, 4'b1000, 4'b1000, 0};
        tbl[27] = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 1};

        stall_req = 4'h0;
        hz = 1'b0; fl = 1'b0; clr = 1'b0;
        rst_n = 1'b1;
        m3 = mreset();
        m4 = mreset();
        #1 rst_n = 1'b0;
        #2 chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 28; i++) begin
            cyc(tbl[i].st, tbl[i].hz, tbl[i].fl, tbl[i].clr);
            chk($sformatf("tbl%0d_flow", i), 32'(f3), 32'(tbl[i].ef));
            chk($sformatf("tbl%0d_bubble", i), 32'(b3), 32'(tbl[i].eb));
            chk($sformatf("tbl%0d_active", i), 32'(sa3), 32'(tbl[i].ef != 4'hF));
            chk($sformatf("tbl%0d_cnt", i), 32'(sc3), 32'(tbl[i].ecnt));
        end

        // four-cycle hazard, then flush from HOLD on the four-cycle instance
        for (int i = 0; i < 5; i++) begin
            cyc(4'h0, i == 0, 1'b0, 1'b0);
            chk($sformatf("haz4_%0d_flow", i), 32'(f4), (i < 4) ? 32'hE : 32'hF);
            chk($sformatf("haz4_%0d_bubble", i), 32'(b4), (i < 4) ? 32'h2 : 32'h0);
        end
        cyc(4'h0, 1'b1, 1'b0, 1'b0);
        chk("flush4_h0_flow", 32'(f4), 32'hE);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("flush4_h1_flow", 32'(f4), 32'hE);
        cyc(4'h0, 1'b0, 1'b1, 1'b0);
        chk("flush4_flow", 32'(f4), 32'hF);
        chk("flush4_bubble", 32'(b4), 32'h3);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("flush4_after_flow", 32'(f4), 32'hF);
        chk("flush4_after_bubble", 32'(b4), 32'h0);

        // watchdog
        for (int i = 1; i <= 12; i++) begin
            cyc(4'b0001, 1'b0, 1'b0, 1'b0);
            chk($sformatf("wd%0d_timeout", i), 32'(to3), 32'(i >= 11));
            chk($sformatf("wd%0d_cnt", i), 32'(sc3), 32'(i - 1));
        end
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("wd_release_timeout", 32'(to3), 32'h1);
        chk("wd_release_cnt", 32'(sc3), 32'd12);
        cyc(4'h0, 1'b0, 1'b0, 1'b1);
        chk("wd_clr_cycle_timeout", 32'(to3), 32'h1);
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("wd_cleared_timeout", 32'(to3), 32'h0);

        // counter saturation
        repeat (260) cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        chk("sat_cnt", 32'(sc3), 32'd255);
        chk("sat_timeout", 32'(to3), 32'h1);

        // asynchronous reset in the middle of a stall with a flush pending
        cyc(4'b0001, 1'b0, 1'b1, 1'b0);
        cyc(4'b0001, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset("midreset");
        stall_req = 4'h0;
        hz = 1'b0; fl = 1'b0; clr = 1'b0;
        m3 = mreset();
        m4 = mreset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4'h0, 1'b0, 1'b0, 1'b0);
        chk("postreset_flow", 32'({f4, f3}), 32'hFF);
        chk("postreset_bubble", 32'({b4, b3}), 32'h00);

        // randomized run against the model
        for (int i = 0; i < 1500; i++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            cyc(st, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_flow_ctrl.md
# pipeline_flow_ctrl

Parametrised pipeline stall, bubble and flush controller. It drives a load-enable (`flow`) and a NOP-insert (`bubble`) for each of `NUM_STAGES` pipeline registers, where register 0 is IF/ID. It replaces the single-source, all-or-nothing stall with three request sources:

- per-stage stall requests;
- a multi-cycle load-use hazard sequencer;
- a pended branch flush.

It also provides a stall-length counter and a watchdog.

## Interface
Parameters:
- `NUM_STAGES`, 4: number of pipeline registers controlled (register 0 = IF/ID, N-1 = MEM/WB).
- `HAZARD_STALL_CYCLES`, 1: IF/ID hold cycles per load-use hazard (≥1).
- `FLUSH_DEPTH`, 2: registers 0..FLUSH_DEPTH-1 are cleared on a flush (1..NUM_STAGES).
- `CNT_W`, 8: width of the stall-cycle counter.
- `TIMEOUT`, 200: consecutive external-stall cycles that raise the watchdog (< 2^CNT_W).

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `stall_req` in NUM_STAGES: `stall_req[i]` means register i cannot advance (e.g. an indirect memory access).
- `hazard_req` in 1: load-use hazard detected in ID.
- `flush_req` in 1: single-cycle pulse requesting a branch-mispredict flush.
- `timeout_clr` in 1: clears `timeout`.
- `flow` out NUM_STAGES: register i loads on the next clk edge.
- `bubble` out NUM_STAGES: register i loads a NOP/invalid instead of upstream data. Only valid when `flow[i]`=1.
- `stall_active` out 1: any `flow` bit is 0.
- `stall_cycles` out CNT_W: consecutive cycles with any `stall_req`, saturating.
- `timeout` out 1: sticky watchdog flag.

## Operation
- **Priority:** external stall > flush > hazard. Defaults are `flow`=all 1 and `bubble`=all 0.
- **External stall:**
  - Let k be the highest index with `stall_req[k]`=1.
  - `flow[j]`=0 for j≤k.
  - `flow[j]`=1 for j>k.
  - `bubble[k+1]`=1 if k+1<NUM_STAGES.
  - Lower stall requests are subsumed by k.
- **Flush:**
  - When `flush_req` (or `flush_pending`) is 1 and no `stall_req` bit is set: all `flow`=1 and `bubble[j]`=1 for j<FLUSH_DEPTH, for exactly one cycle.
  - That cycle clears `flush_pending` and cancels the hazard FSM to IDLE.
  - If `flush_req` arrives while any `stall_req` is set, `flush_pending` is set and the flush is applied in the first cycle with `stall_req`=0.
  - Multiple flush pulses while pending merge into one flush.
- **Hazard FSM:**
  - States IDLE and HOLD, with `haz_cnt` of width clog2(HAZARD_STALL_CYCLES+1).
  - In IDLE, `hazard_req`=1 with no stall and no flush makes that cycle a hazard cycle. If HAZARD_STALL_CYCLES>1, go to HOLD with `haz_cnt`=HAZARD_STALL_CYCLES-1.
  - In HOLD, each cycle with no stall and no flush is a hazard cycle and decrements `haz_cnt`. Return to IDLE after the cycle in which `haz_cnt`=1.
  - A hazard cycle drives `flow[0]`=0, `flow[1]`=1, `bubble[1]`=1, and all other `flow`=1.
  - An external stall freezes `haz_cnt` and the state.
  - `hazard_req` in HOLD is ignored.
  - `hazard_req` in IDLE during a stall or flush cycle is dropped; the ID stage re-asserts it.
- **Counter and watchdog:**
  - `stall_cycles` increments each cycle any `stall_req`=1, saturates at 2^CNT_W-1, and returns to 0 on the first edge with `stall_req`=0.
  - `timeout` is set on the edge where `stall_cycles` reaches TIMEOUT.
  - `timeout` is cleared only by `timeout_clr` or reset. If set and clear coincide, set wins.
- **Edge cases:** NUM_STAGES=1 means `bubble[1]` terms are absent, and the hazard drives only `flow[0]`=0.

## Timing
- `flow`, `bubble` and `stall_active` are combinational from the inputs and registered state, with zero-cycle latency.
- Registers of interest (FSM, `haz_cnt`, `flush_pending`, `stall_cycles`, `timeout`) update on the rising `clk` edge.
- Reset (`rst_n`=0, asynchronous, effective immediately):
  - `flow`=all 0, `bubble`=all 1, `stall_active`=1;
  - `stall_cycles`=0, `timeout`=0, FSM=IDLE, `flush_pending`=0.
- Reset mid-hazard or mid-pending-flush discards that hazard or flush.
- First cycle after `rst_n` deasserts: outputs follow the normal rules.
- A hazard costs exactly HAZARD_STALL_CYCLES unstalled cycles. External stall cycles add to that total without consuming it.

## Test plan
- **Single-stage stall.** NUM_STAGES=4, `stall_req`=4'b0100 for 3 cycles. Required: `flow`=4'b1000 and `bubble`=4'b1000 for those 3 cycles; `stall_cycles` reads 1, 2, 3, then 0 after release.
- **Hazard length.** HAZARD_STALL_CYCLES=3, one-cycle `hazard_req` pulse. Required: `flow`=4'b1110 and `bubble`=4'b0010 for 3 consecutive cycles, then all-flow.
- **Stall during hazard.** Same pulse, with `stall_req`=4'b0001 in the 2nd hazard cycle. Required: hazard cycles total 3, and the stalled cycle shows `flow`=4'b1110, `bubble`=4'b0010.
- **Pended flush.** `flush_req` pulse while `stall_req`=4'b1000 for 5 cycles. Required: `flow`=0 during the stall; in the first cycle with `stall_req`=0, `flow`=4'b1111 and `bubble`=4'b0011, for exactly one cycle.
- **Flush cancels hazard.** `flush_req` in HOLD (HAZARD_STALL_CYCLES=4). Required: a flush cycle, then FSM IDLE with all-flow on the next cycle.
- **Watchdog and reset.** TIMEOUT=10, `stall_req`=4'b0001 held for 12 cycles. Required: `timeout` rises on the 10th edge and stays after release; `timeout_clr` clears it. `rst_n` low mid-test forces `flow`=0, `bubble`=all 1, `stall_cycles`=0 immediately.
